// File: rtl/acc_multi_pkg.sv
// Shared types and arithmetic helpers for the multi-lane unary accumulator.
package acc_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Widest lane the helpers support; lanes must be strictly narrower so the
    // sign-extended add can never overflow its own container.
    localparam int MAX_W = 64;

    typedef struct packed {
        logic             ovf;
        logic [MAX_W-1:0] sum;
    } add_res_t;

    // Largest signed value representable in 'width' bits.
    function automatic logic signed [MAX_W-1:0] sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Smallest signed value representable in 'width' bits.
    function automatic logic signed [MAX_W-1:0] sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    // base + prod, optionally clamped to the signed range of 'width' bits.
    // Without saturation the caller keeps the low 'width' bits, which wraps.
    function automatic add_res_t sat_add(input logic signed [MAX_W-1:0] base,
                                         input logic signed [1:0]       prod,
                                         input logic                    sat,
                                         input int                      width);
        add_res_t                r;
        logic signed [MAX_W-1:0] s;
        s     = base + $signed({{(MAX_W-2){prod[1]}}, prod});
        r.ovf = 1'b0;
        r.sum = s;
        if (sat) begin
            if (s > sat_max(width)) begin
                r.ovf = 1'b1;
                r.sum = sat_max(width);
            end else if (s < sat_min(width)) begin
                r.ovf = 1'b1;
                r.sum = sat_min(width);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_lane.sv
// One accumulator lane: decodes the unary product bit into -1/0/+1, adds it to
// either its own count or the upstream partial sum, and keeps a sticky
// saturation flag.
module acc_lane
    import acc_multi_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             zero,
    input  logic             upd,
    input  logic             acc,
    input  logic             mode,
    input  logic             sign_i,
    input  logic             sign_w,
    input  logic             prod_bit,
    input  logic [WIDTH-1:0] sum_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             ovf
);

    logic signed [1:0] prod;
    logic [WIDTH-1:0]  base;
    logic [WIDTH-1:0]  sum_reg;
    logic              ovf_reg;
    add_res_t          res;
    logic              unused_hi;

    // Product decode and the widened add for this lane.
    always_comb begin
        prod = 2'sd0;
        if (prod_bit) begin
            prod = (mode & (sign_i ^ sign_w)) ? -2'sd1 : 2'sd1;
        end
        base = acc ? sum_i : sum_reg;
        res  = sat_add($signed({{(MAX_W-WIDTH){base[WIDTH-1]}}, base}), prod, SAT, WIDTH);
    end

    // Only the low WIDTH bits of the widened result are kept.
    assign unused_hi = ^res.sum[MAX_W-1:WIDTH];

    // Lane count and sticky overflow; zero wins over an update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (zero) begin
            sum_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (upd) begin
            sum_reg <= res.sum[WIDTH-1:0];
            ovf_reg <= ovf_reg | res.ovf;
        end
    end

    assign sum_o = sum_reg;
    assign ovf   = ovf_reg;

endmodule

// File: rtl/acc_multi_win.sv
// Multi-lane windowed unary-rate accumulator: window FSM, en-cycle counter and
// valid/ready result handshake around LANES independent accumulator lanes.
module acc_multi_win
    import acc_multi_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int CYC_W = 8,
    parameter int SAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   start,
    input  logic [CYC_W-1:0]       win_len,
    input  logic                   bipolar,
    input  logic                   en,
    input  logic                   acc,
    input  logic [LANES-1:0]       sign_i,
    input  logic [LANES-1:0]       sign_w,
    input  logic [LANES-1:0]       prod_bit,
    input  logic [LANES*WIDTH-1:0] sum_i,
    output logic [LANES*WIDTH-1:0] sum_o,
    output logic [LANES-1:0]       ovf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    state_t           state_reg, state_next;
    logic [CYC_W-1:0] cnt_reg, cnt_next;
    logic             mode_reg, mode_next;
    logic             lane_zero;
    logic             lane_upd;

    // Next-state logic: clr overrides everything; a start accepted in IDLE or
    // together with out_ready in DONE zeroes the lanes and opens a window.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        lane_zero  = 1'b0;
        lane_upd   = 1'b0;
        if (clr) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            lane_zero  = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        lane_zero  = 1'b1;
                        mode_next  = bipolar;
                        cnt_next   = win_len;
                        state_next = (win_len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        lane_upd = 1'b1;
                        cnt_next = cnt_reg - CYC_W'(1);
                        if (cnt_reg == CYC_W'(1)) begin
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        if (start) begin
                            lane_zero  = 1'b1;
                            mode_next  = bipolar;
                            cnt_next   = win_len;
                            state_next = (win_len == '0) ? ST_DONE : ST_RUN;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state, remaining en-cycle count and latched sign mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            mode_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
        end
    end

    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg == ST_RUN);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            acc_lane #(
                .WIDTH (WIDTH),
                .SAT   (SAT != 0)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .zero     (lane_zero),
                .upd      (lane_upd),
                .acc      (acc),
                .mode     (mode_reg),
                .sign_i   (sign_i[gi]),
                .sign_w   (sign_w[gi]),
                .prod_bit (prod_bit[gi]),
                .sum_i    (sum_i[gi*WIDTH +: WIDTH]),
                .sum_o    (sum_o[gi*WIDTH +: WIDTH]),
                .ovf      (ovf[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_acc_multi_win.sv
// Bench for acc_multi_win: a saturating and a wrapping instance share all
// inputs and are compared against an integer reference model.
module tb_acc_multi_win;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int CYC_W = 8;
    localparam int HMAX  = (1 << (WIDTH - 1)) - 1;
    localparam int HMIN  = -(1 << (WIDTH - 1));
    localparam int FULL  = 1 << WIDTH;

    logic                   clk = 1'b0;
    logic                   rst, clr, start, bipolar, en, acc, out_ready;
    logic [CYC_W-1:0]       win_len;
    logic [LANES-1:0]       sign_i, sign_w, prod_bit;
    logic [LANES*WIDTH-1:0] sum_i;
    logic [LANES*WIDTH-1:0] sum_o_s, sum_o_w;
    logic [LANES-1:0]       ovf_s, ovf_w;
    logic                   valid_s, valid_w, busy_s, busy_w;

    int tests_run    = 0;
    int tests_failed = 0;

    int               exp_sat [LANES];
    int               exp_wrap[LANES];
    logic [LANES-1:0] exp_ovf;
    bit               mode_m;

    always #5 clk = ~clk;

    acc_multi_win #(.WIDTH(WIDTH), .LANES(LANES), .CYC_W(CYC_W), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .win_len(win_len),
        .bipolar(bipolar), .en(en), .acc(acc), .sign_i(sign_i), .sign_w(sign_w),
        .prod_bit(prod_bit), .sum_i(sum_i), .sum_o(sum_o_s), .ovf(ovf_s),
        .out_valid(valid_s), .out_ready(out_ready), .busy(busy_s)
    );

    acc_multi_win #(.WIDTH(WIDTH), .LANES(LANES), .CYC_W(CYC_W), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .win_len(win_len),
        .bipolar(bipolar), .en(en), .acc(acc), .sign_i(sign_i), .sign_w(sign_w),
        .prod_bit(prod_bit), .sum_i(sum_i), .sum_o(sum_o_w), .ovf(ovf_w),
        .out_valid(valid_w), .out_ready(out_ready), .busy(busy_w)
    );

    // ---------------- reference model ----------------
    function automatic int wrap_val(input int v);
        return (((v - HMIN) % FULL) + FULL) % FULL + HMIN;
    endfunction

    function automatic logic [LANES*WIDTH-1:0] exp_bus(input bit wrap_inst);
        logic [LANES*WIDTH-1:0] b;
        for (int k = 0; k < LANES; k++)
            b[k*WIDTH +: WIDTH] = WIDTH'(wrap_inst ? exp_wrap[k] : exp_sat[k]);
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < LANES; k++) begin
            exp_sat[k]  = 0;
            exp_wrap[k] = 0;
        end
        exp_ovf = '0;
    endtask

    // One en cycle of the window, applied to the currently driven inputs.
    task automatic model_en_cycle();
        for (int k = 0; k < LANES; k++) begin
            logic signed [WIDTH-1:0] si;
            int p, b, v;
            si = sum_i[k*WIDTH +: WIDTH];
            p  = 0;
            if (prod_bit[k]) p = (mode_m && (sign_i[k] ^ sign_w[k])) ? -1 : 1;
            b = acc ? int'(si) : exp_sat[k];
            v = b + p;
            if (v > HMAX) begin
                v = HMAX;
                exp_ovf[k] = 1'b1;
            end else if (v < HMIN) begin
                v = HMIN;
                exp_ovf[k] = 1'b1;
            end
            exp_sat[k] = v;
            b = acc ? int'(si) : exp_wrap[k];
            exp_wrap[k] = wrap_val(b + p);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues start (with out_ready so it also works from DONE).
    task automatic start_window(input int wl, input bit bip);
        win_len   = CYC_W'(wl);
        bipolar   = bip;
        start     = 1'b1;
        out_ready = 1'b1;
        en        = 1'b0;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        mode_m = bip;
    endtask

    // en_mode: 0 = always, 1 = toggle starting low, 2 = random.
    task automatic run_window(input int wl, input int en_mode, input bit rnd,
                              output int clocks, output int busy_clks);
        int n;
        n = 0;
        clocks = 0;
        busy_clks = 0;
        while (n < wl && clocks < 4 * wl + 50) begin
            case (en_mode)
                0:       en = 1'b1;
                1:       en = clocks[0];
                default: en = 1'($urandom_range(0, 1));
            endcase
            if (rnd) begin
                prod_bit = LANES'($urandom);
                sign_i   = LANES'($urandom);
                sign_w   = LANES'($urandom);
                acc      = ($urandom_range(0, 3) == 0);
                for (int k = 0; k < LANES; k++) begin
                    case ($urandom_range(0, 3))
                        0:       sum_i[k*WIDTH +: WIDTH] = WIDTH'(HMAX);
                        1:       sum_i[k*WIDTH +: WIDTH] = WIDTH'(HMIN);
                        default: sum_i[k*WIDTH +: WIDTH] = WIDTH'($urandom);
                    endcase
                end
            end
            if (busy_s) busy_clks++;
            if (en) begin
                model_en_cycle();
                n++;
            end
            tick();
            clocks++;
        end
        en  = 1'b0;
        acc = 1'b0;
    endtask

    task automatic finish_handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; start = 1'b0; bipolar = 1'b0; en = 1'b0; acc = 1'b0;
        out_ready = 1'b0; win_len = '0; sign_i = '0; sign_w = '0; prod_bit = '0; sum_i = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        tests_run++;
        if ({sum_o_s, sum_o_w} !== '0) begin
            tests_failed++;
            $display("FAIL reset_sum: got %h/%h expected 0", sum_o_s, sum_o_w);
        end
        tests_run++;
        if ({ovf_s, ovf_w, valid_s, valid_w, busy_s, busy_w} !== '0) begin
            tests_failed++;
            $display("FAIL reset_flags: ovf %b/%b valid %b/%b busy %b/%b expected all 0",
                     ovf_s, ovf_w, valid_s, valid_w, busy_s, busy_w);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_unipolar();
        int c, b;
        prod_bit = 4'hF; sign_i = 4'hA; sign_w = 4'h0; acc = 1'b0;
        start_window(5, 0);
        run_window(5, 0, 0, c, b);
        tests_run++;
        if (sum_o_s !== 32'h05050505 || sum_o_w !== 32'h05050505) begin
            tests_failed++;
            $display("FAIL unipolar_sum: got %h/%h expected 05050505", sum_o_s, sum_o_w);
        end
        tests_run++;
        if (b != 5 || busy_s !== 1'b0 || valid_s !== 1'b1) begin
            tests_failed++;
            $display("FAIL unipolar_timing: busy cycles %0d busy %b valid %b expected 5/0/1",
                     b, busy_s, valid_s);
        end
        finish_handshake();
        tests_run++;
        if (valid_s !== 1'b0 || valid_w !== 1'b0) begin
            tests_failed++;
            $display("FAIL unipolar_release: valid %b/%b expected 0", valid_s, valid_w);
        end
        $display("[TB] unipolar window: sum %h busy_cycles %0d", sum_o_s, b);
    endtask

    task automatic test_bipolar();
        int c, b;
        prod_bit = 4'hF; sign_i = 4'b0011; sign_w = 4'b0010;
        start_window(10, 1);
        run_window(10, 1, 0, c, b);
        tests_run++;
        if (c != 20 || valid_s !== 1'b1) begin
            tests_failed++;
            $display("FAIL bipolar_timing: clocks %0d valid %b expected 20/1", c, valid_s);
        end
        tests_run++;
        if (sum_o_s !== 32'h0A0A0AF6 || sum_o_s !== exp_bus(0)) begin
            tests_failed++;
            $display("FAIL bipolar_sum: got %h expected 0a0a0af6 (model %h)", sum_o_s, exp_bus(0));
        end
        finish_handshake();
        $display("[TB] bipolar window: sum %h clocks %0d", sum_o_s, c);
    endtask

    task automatic test_saturation();
        int c, b;
        prod_bit = 4'hF; sign_i = 4'h0; sign_w = 4'h0;
        start_window(200, 0);
        run_window(200, 0, 0, c, b);
        tests_run++;
        if (sum_o_s !== 32'h7F7F7F7F || ovf_s !== 4'hF) begin
            tests_failed++;
            $display("FAIL sat_clamp: got %h ovf %b expected 7f7f7f7f ovf 1111", sum_o_s, ovf_s);
        end
        tests_run++;
        if (sum_o_w !== 32'hC8C8C8C8 || ovf_w !== 4'h0 || valid_w !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_wrap: got %h ovf %b valid %b expected c8c8c8c8 ovf 0000 valid 1",
                     sum_o_w, ovf_w, valid_w);
        end
        // Back-to-back restart must clear the sticky flag.
        start_window(1, 0);
        tests_run++;
        if (ovf_s !== 4'h0 || sum_o_s !== '0 || busy_s !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_restart: ovf %b sum %h busy %b expected 0000/0/1", ovf_s, sum_o_s, busy_s);
        end
        run_window(1, 0, 0, c, b);
        finish_handshake();
        $display("[TB] saturation window: sat %h wrap %h", 32'h7F7F7F7F, 32'hC8C8C8C8);
    endtask

    task automatic test_chain();
        int c, b;
        prod_bit = 4'b0100; sign_i = '0; sign_w = '0;
        sum_i = 32'h00640000;
        start_window(1, 0);
        acc = 1'b1;
        run_window(1, 0, 0, c, b);
        tests_run++;
        if (sum_o_s !== 32'h00650000 || sum_o_w !== 32'h00650000 || valid_s !== 1'b1) begin
            tests_failed++;
            $display("FAIL chain_sum: got %h/%h valid %b expected 00650000 valid 1",
                     sum_o_s, sum_o_w, valid_s);
        end
        finish_handshake();
        sum_i = '0;
        $display("[TB] chain window: sum %h", sum_o_s);
    endtask

    task automatic test_back_to_back();
        int c, b;
        bit stable;
        prod_bit = 4'hF; sign_i = '0; sign_w = '0;
        start_window(4, 0);
        run_window(4, 0, 0, c, b);
        stable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            en = 1'b1; acc = 1'b1; prod_bit = LANES'($urandom); sum_i = 32'($urandom);
            tick();
            if (valid_s !== 1'b1 || sum_o_s !== 32'h04040404 || busy_s !== 1'b0) stable = 1'b0;
        end
        en = 1'b0; acc = 1'b0; prod_bit = 4'hF; sum_i = '0;
        tests_run++;
        if (!stable) begin
            tests_failed++;
            $display("FAIL done_hold: sum %h valid %b busy %b expected 04040404/1/0 for 7 cycles",
                     sum_o_s, valid_s, busy_s);
        end
        start_window(3, 0);
        tests_run++;
        if (valid_s !== 1'b0 || busy_s !== 1'b1 || sum_o_s !== '0) begin
            tests_failed++;
            $display("FAIL b2b_restart: valid %b busy %b sum %h expected 0/1/0", valid_s, busy_s, sum_o_s);
        end
        run_window(3, 0, 0, c, b);
        tests_run++;
        if (sum_o_s !== 32'h03030303 || valid_s !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h valid %b expected 03030303 valid 1", sum_o_s, valid_s);
        end
        finish_handshake();
        $display("[TB] back-to-back windows: second sum %h", sum_o_s);
    endtask

    task automatic test_clr();
        prod_bit = 4'hF;
        start_window(5, 0);
        en = 1'b1;
        tick(); tick();
        clr = 1'b1; start = 1'b1; win_len = 8'd5;
        tick();
        clr = 1'b0; start = 1'b0;
        tests_run++;
        if (sum_o_s !== '0 || valid_s !== 1'b0 || busy_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_mid_run: sum %h valid %b busy %b expected 0/0/0", sum_o_s, valid_s, busy_s);
        end
        tick(); tick(); tick();
        en = 1'b0;
        tests_run++;
        if (sum_o_s !== '0 || valid_s !== 1'b0 || busy_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_idle: sum %h valid %b busy %b expected 0/0/0", sum_o_s, valid_s, busy_s);
        end
        $display("[TB] clr mid-window: sum %h", sum_o_s);
    endtask

    task automatic test_async_rst();
        prod_bit = 4'hF;
        start_window(5, 0);
        en = 1'b1;
        tick(); tick();
        #3 rst = 1'b1;
        en = 1'b0;
        #1;
        tests_run++;
        if ({sum_o_s, sum_o_w} !== '0 || valid_s !== 1'b0 || busy_s !== 1'b0 || ovf_s !== '0) begin
            tests_failed++;
            $display("FAIL async_rst: sum %h/%h valid %b busy %b ovf %b expected all 0",
                     sum_o_s, sum_o_w, valid_s, busy_s, ovf_s);
        end
        #2 rst = 1'b0;
        tick();
        tests_run++;
        if (busy_s !== 1'b0 || valid_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_rst_idle: busy %b valid %b expected 0/0", busy_s, valid_s);
        end
        $display("[TB] async reset mid-window");
    endtask

    task automatic test_win_zero();
        int c, b;
        prod_bit = 4'hF;
        start_window(3, 0);
        run_window(3, 0, 0, c, b);
        start_window(0, 0);
        tests_run++;
        if (valid_s !== 1'b1 || busy_s !== 1'b0 || sum_o_s !== '0) begin
            tests_failed++;
            $display("FAIL win_zero_from_done: valid %b busy %b sum %h expected 1/0/0", valid_s, busy_s, sum_o_s);
        end
        finish_handshake();
        start_window(0, 0);
        tests_run++;
        if (valid_s !== 1'b1 || busy_s !== 1'b0 || sum_o_s !== '0) begin
            tests_failed++;
            $display("FAIL win_zero_from_idle: valid %b busy %b sum %h expected 1/0/0", valid_s, busy_s, sum_o_s);
        end
        finish_handshake();
        $display("[TB] zero-length windows");
    endtask

    task automatic test_random();
        int c, b, wl;
        bit bip;
        for (int w = 0; w < 24; w++) begin
            wl  = $urandom_range(1, 12);
            bip = 1'($urandom_range(0, 1));
            start_window(wl, bip);
            tests_run++;
            if ({sum_o_s, sum_o_w, ovf_s, ovf_w} !== '0) begin
                tests_failed++;
                $display("FAIL rand_start[%0d]: sum %h/%h ovf %b/%b expected 0", w, sum_o_s, sum_o_w, ovf_s, ovf_w);
            end
            run_window(wl, 2, 1, c, b);
            tests_run++;
            if (valid_s !== 1'b1 || valid_w !== 1'b1 || sum_o_s !== exp_bus(0) || ovf_s !== exp_ovf) begin
                tests_failed++;
                $display("FAIL rand_sat[%0d]: sum %h ovf %b valid %b expected %h ovf %b valid 1",
                         w, sum_o_s, ovf_s, valid_s, exp_bus(0), exp_ovf);
            end
            tests_run++;
            if (sum_o_w !== exp_bus(1) || ovf_w !== '0) begin
                tests_failed++;
                $display("FAIL rand_wrap[%0d]: sum %h ovf %b expected %h ovf 0000",
                         w, sum_o_w, ovf_w, exp_bus(1));
            end
            $display("[TB] random window %0d: len %0d bip %0d sat %h wrap %h ovf %b",
                     w, wl, bip, sum_o_s, sum_o_w, ovf_s);
            if ($urandom_range(0, 1) == 0) finish_handshake();
        end
        finish_handshake();
    endtask

    initial begin
        test_reset();
        test_unipolar();
        test_bipolar();
        test_saturation();
        test_chain();
        test_back_to_back();
        test_clr();
        test_async_rst();
        test_win_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/acc_multi_win.md
Name: acc_multi_win

Overview:
- Multi-lane unary-rate accumulator for the systolic PE column.
- Each lane integrates a serial unary product bitstream over a programmable window, with optional partial-sum chaining from the upstream PE and optional saturation.
- At window end, each lane presents its signed counts on a valid/ready port to the drain/output buffer.
- Replaces the single-lane free-running accumulator: adds lanes, window control, sign mode, saturation and handshake.

Parameters:
- WIDTH, 32, bits per lane accumulator (signed two's complement), >=2
- LANES, 4, number of independent accumulator lanes, >=1
- CYC_W, 8, width of window-length counter
- SAT, 1, 1 = saturate at signed min/max with sticky overflow flag; 0 = wrap modulo 2^WIDTH

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear: zero lanes, drop valid, go IDLE
- start  in  1  begin window; loads counter from win_len
- win_len  in  CYC_W  number of en cycles in the window; sampled on accepted start
- bipolar  in  1  0 = unipolar (+1 per bit); 1 = sign-magnitude (sign_i XOR sign_w gives -1); sampled on accepted start
- en  in  1  unary bit strobe, common to all lanes
- acc  in  1  1 = add to upstream sum_i instead of own register (chain mode)
- sign_i  in  LANES  per-lane input sign
- sign_w  in  LANES  per-lane weight sign
- prod_bit  in  LANES  per-lane unary product bit
- sum_i  in  LANES*WIDTH  upstream partial sums, lane k at [k*WIDTH +: WIDTH]
- sum_o  out  LANES*WIDTH  lane accumulators, same packing
- ovf  out  LANES  sticky per-lane saturation flag (0 when SAT=0)
- out_valid  out  1  window complete, sum_o stable
- out_ready  in  1  downstream accepts sum_o
- busy  out  1  high in RUN

Behaviour:
- Reset (rst=1, async): sum_o=0, ovf=0, out_valid=0, busy=0, counter=0, mode=0, state IDLE.
- Priority per cycle: rst > clr > FSM actions.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1: zero sum_o and ovf, latch bipolar, load cnt=win_len.
  - If win_len=0, go to DONE; otherwise go to RUN.
- RUN (busy=1):
  - On each en=1 cycle, each lane updates sum_o[k] <= base + prod[k], where base = acc ? sum_i[k] : sum_o[k].
  - prod[k] = prod_bit[k] ? (mode & (sign_i[k]^sign_w[k]) ? -1 : +1) : 0.
  - Each en=1 cycle decrements cnt. When cnt==1 and en=1, go to DONE on the same edge as the last update.
  - en=0 holds everything; the window counts en cycles, not clock cycles.
  - start in RUN is ignored.
- DONE:
  - out_valid=1; sum_o and ovf held, en ignored.
  - out_ready=1 completes the handshake: out_valid drops next cycle and the FSM returns to IDLE.
  - out_ready=1 together with start=1 restarts directly into RUN (or DONE if win_len=0), zeroing lanes. This gives back-to-back windows with no bubble.
  - out_valid must not drop without out_ready, except on clr or rst.
- Latency: sum_o reflects an en cycle on the next edge. out_valid rises on the edge of the final en cycle's update.
- Arithmetic: the add is WIDTH+1 bits wide.
  - SAT=1: a result above 2^(WIDTH-1)-1 clamps to max; a result below -2^(WIDTH-1) clamps to min. Either case sets ovf[k] sticky until the next start, clr or rst.
  - SAT=0: wrap, and ovf stays 0.
  - Unipolar mode ignores sign inputs.
- clr mid-RUN or in DONE: lanes zeroed, out_valid=0, state IDLE on the next edge. clr wins over a simultaneous start.
- Lanes are fully independent except for the shared en/acc/start/window control.

Decomposition:
- Package acc_multi_pkg:
  - state enum (IDLE, RUN, DONE)
  - localparams for signed max/min per WIDTH
  - helper function sat_add(base, prod, sat) returning {ovf, sum}
- Sub-module acc_lane:
  - one lane: prod decode, saturating add, register, sticky ovf
  - generated LANES times
- Top level holds the FSM, window counter and handshake.

Test Plan:
1. LANES=4, WIDTH=8, win_len=5, unipolar, prod_bit=4'b1111 every cycle, en=1 -> out_valid rises after the 5th en edge; all lanes =5; busy high for exactly 5 cycles.
2. Bipolar, lane0 sign_i=1/sign_w=0, lane1 both=1, prod_bit=1 for 10 en cycles with en toggling 1/0 -> DONE after 10 en pulses (20 clocks); lane0=-10, lane1=+10.
3. WIDTH=8, SAT=1, win_len=200, unipolar all-ones -> lanes clamp at 127 with ovf=1. Repeat with SAT=0 -> lanes=200-256=-56, ovf=0.
4. Chain mode acc=1, sum_i lane2=100, prod_bit lane2=1, win_len=1 -> sum_o lane2=101, out_valid next cycle.
5. Handshake: hold out_ready=0 for 7 cycles in DONE -> sum_o/out_valid stable throughout. Then out_ready=1 with start=1, win_len=3 -> out_valid=0 next cycle, busy=1, lanes=0.
6. clr asserted at en-cycle 2 of 5 -> lanes=0, IDLE, no out_valid. rst pulse asserted asynchronously mid-RUN, between clock edges -> outputs zero immediately. win_len=0 start -> out_valid next cycle with lanes=0.
